// File: rtl/tristate_oe_ctrl_if.sv
// Bus bundle between a single requester and the tristate enable controller.
// The master side raises req and supplies wdata.
// The slave side, the controller, returns the grant, the registered drive data and enable, and the status flags.
interface tristate_oe_ctrl_if #(
    parameter int WIDTH = 1
);
    logic             req;
    logic [WIDTH-1:0] wdata;
    logic             grant;
    logic [WIDTH-1:0] drv_data;
    logic             drv_en;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output wdata,
        input  grant,
        input  drv_data,
        input  drv_en,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  wdata,
        output grant,
        output drv_data,
        output drv_en,
        output busy,
        output timeout
    );
endinterface

// File: rtl/tristate_oe_ctrl.sv
// Upstream control for a notif1-style tristate driver.
// It produces a registered data/enable pair and serves one requester with a req/grant handshake.
// TURN_CYC dead cycles with the enable low are placed before every drive and after it.
// Optional build macro TRI_TIMEOUT_EN adds a watchdog.
// The watchdog limits a drive to MAX_DRIVE cycles, pulses timeout on a forced release,
// and locks out re-entry until req has been seen low once.
module tristate_oe_ctrl #(
    parameter int WIDTH     = 1,
    parameter int TURN_CYC  = 2,
    parameter int MAX_DRIVE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tristate_oe_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, TURN_ON, DRIVE, TURN_OFF} state_t;

    // Dead counter is clog2(TURN_CYC+1) bits; kept at least 1 bit wide so TURN_CYC=0 still elaborates.
    localparam int CW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
    localparam logic [CW-1:0] TURN_LOAD = (TURN_CYC > 0) ? CW'(TURN_CYC - 1) : '0;
    localparam bit NO_TURN = (TURN_CYC == 0);

    if (MAX_DRIVE < 1 || TURN_CYC < 0) begin : g_bad_param
        $error("tristate_oe_ctrl: MAX_DRIVE must be >= 1 and TURN_CYC >= 0");
    end

    state_t           state_reg, state_next;
    logic [CW-1:0]    dead_cnt_reg, dead_cnt_next;
    logic [WIDTH-1:0] drv_data_reg, drv_data_next;
    logic             drv_en_reg;
    logic             busy_reg;
    logic             locked;
    logic             drive_limit;

    // Next-state, dead-counter and data-capture decode.
    always_comb begin
        state_next    = state_reg;
        dead_cnt_next = dead_cnt_reg;
        drv_data_next = drv_data_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req && !locked) begin
                    if (NO_TURN) begin
                        state_next = DRIVE;
                    end else begin
                        state_next    = TURN_ON;
                        dead_cnt_next = TURN_LOAD;
                    end
                end
            end
            TURN_ON: begin
                if (!bus.req) begin
                    state_next = IDLE;
                end else if (dead_cnt_reg == '0) begin
                    state_next = DRIVE;
                end else begin
                    dead_cnt_next = dead_cnt_reg - 1'b1;
                end
            end
            DRIVE: begin
                if (!bus.req || drive_limit) begin
                    if (NO_TURN) begin
                        state_next = IDLE;
                    end else begin
                        state_next    = TURN_OFF;
                        dead_cnt_next = TURN_LOAD;
                    end
                end
            end
            TURN_OFF: begin
                // The expiry edge doubles as the IDLE sampling edge.
                // A held request goes straight to TURN_ON and still pays the full turn-on dead time.
                if (dead_cnt_reg == '0) begin
                    if (bus.req && !locked) begin
                        state_next    = TURN_ON;
                        dead_cnt_next = TURN_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    dead_cnt_next = dead_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == DRIVE) begin
            drv_data_next = bus.wdata;
        end
    end

    // State, counter and registered outputs.
    // Reset drops the enable at once, with no dead time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            dead_cnt_reg <= '0;
            drv_data_reg <= '0;
            drv_en_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dead_cnt_reg <= dead_cnt_next;
            drv_data_reg <= drv_data_next;
            drv_en_reg   <= (state_next == DRIVE);
            busy_reg     <= (state_next != IDLE);
        end
    end

`ifdef TRI_TIMEOUT_EN
    localparam int DW = $clog2(MAX_DRIVE + 1);

    logic [DW-1:0] drive_cnt_reg;
    logic          lock_reg;
    logic          timeout_reg;
    logic          force_exit;

    assign drive_limit = (drive_cnt_reg == DW'(MAX_DRIVE - 1));
    assign force_exit  = (state_reg == DRIVE) && bus.req && drive_limit;
    assign locked      = lock_reg;

    // Watchdog: count completed DRIVE cycles, latch the lockout and pulse timeout on a forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_cnt_reg <= '0;
            lock_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            if (state_reg == DRIVE && state_next == DRIVE) begin
                drive_cnt_reg <= drive_cnt_reg + 1'b1;
            end else begin
                drive_cnt_reg <= '0;
            end
            if (!bus.req) begin
                lock_reg <= 1'b0;
            end else if (force_exit) begin
                lock_reg <= 1'b1;
            end
            timeout_reg <= force_exit;
        end
    end

    assign bus.timeout = timeout_reg;
`else
    assign drive_limit = 1'b0;
    assign locked      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.drv_data = drv_data_reg;
    assign bus.drv_en   = drv_en_reg;
    assign bus.grant    = drv_en_reg;
    assign bus.busy     = busy_reg;
endmodule

// File: tb/tb_tristate_oe_ctrl.sv
// Directed bench for tristate_oe_ctrl.
// DUT a uses TURN_CYC=2 and DUT b uses TURN_CYC=0.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_tristate_oe_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    tristate_oe_ctrl_if #(.WIDTH(1)) bus_a ();
    tristate_oe_ctrl_if #(.WIDTH(1)) bus_b ();

    tristate_oe_ctrl #(.WIDTH(1), .TURN_CYC(2), .MAX_DRIVE(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    tristate_oe_ctrl #(.WIDTH(1), .TURN_CYC(0), .MAX_DRIVE(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s = %0h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        int to_cnt;
        bus_a.req = 1'b0; bus_a.wdata = 1'b0;
        bus_b.req = 1'b0; bus_b.wdata = 1'b0;

        // Reset state
        #2;
        check("rst drv_en", bus_a.drv_en, 0);
        check("rst grant", bus_a.grant, 0);
        check("rst busy", bus_a.busy, 0);
        check("rst drv_data", bus_a.drv_data, 0);
        check("rst timeout", bus_a.timeout, 0);
        step(); step();
        rst_n = 1'b1;
        step(); step();

        // Basic transfer, TURN_CYC=2
        bus_a.req = 1'b1; bus_a.wdata = 1'b1;
        step();
        check("on N drv_en", bus_a.drv_en, 0);
        check("on N busy", bus_a.busy, 1);
        step();
        check("on N+1 drv_en", bus_a.drv_en, 0);
        step();
        check("on N+2 drv_en", bus_a.drv_en, 1);
        check("on N+2 grant", bus_a.grant, 1);
        check("on N+2 drv_data", bus_a.drv_data, 1);
        for (int i = 0; i < 6; i++) begin
            bus_a.wdata = i[0];
            step();
            check($sformatf("follow %0d", i), bus_a.drv_data, i[0]);
        end
        // Last captured value was 1; data arriving on the release edge must not be captured
        bus_a.wdata = 1'b0;
        bus_a.req = 1'b0;
        step();
        check("off M drv_en", bus_a.drv_en, 0);
        check("off M grant", bus_a.grant, 0);
        check("off M busy", bus_a.busy, 1);
        check("off M drv_data hold", bus_a.drv_data, 1);
        step();
        check("off M+1 busy", bus_a.busy, 1);
        step();
        check("off M+2 busy", bus_a.busy, 0);
        step();

        // Back-to-back: req low for the release edge only
        bus_a.req = 1'b1; bus_a.wdata = 1'b1;
        step(); step(); step();
        check("b2b drive", bus_a.drv_en, 1);
        step();
        bus_a.req = 1'b0;
        step();
        check("b2b M drv_en", bus_a.drv_en, 0);
        bus_a.req = 1'b1;
        step();
        check("b2b M+1 drv_en", bus_a.drv_en, 0);
        step();
        check("b2b M+2 drv_en", bus_a.drv_en, 0);
        check("b2b M+2 busy", bus_a.busy, 1);
        step();
        check("b2b M+3 drv_en", bus_a.drv_en, 0);
        step();
        check("b2b M+4 drv_en", bus_a.drv_en, 1);
        bus_a.req = 1'b0;
        step(); step(); step();
        check("b2b settle busy", bus_a.busy, 0);

        // Abort: one-cycle req pulse
        bus_a.req = 1'b1;
        step();
        check("abort TURN_ON busy", bus_a.busy, 1);
        bus_a.req = 1'b0;
        step();
        check("abort drv_en", bus_a.drv_en, 0);
        check("abort busy", bus_a.busy, 0);
        step();
        check("abort drv_en later", bus_a.drv_en, 0);

        // Zero dead time on DUT b
        bus_b.req = 1'b1; bus_b.wdata = 1'b1;
        step();
        check("z0 drv_en", bus_b.drv_en, 1);
        check("z0 drv_data", bus_b.drv_data, 1);
        bus_b.wdata = 1'b0;
        step();
        check("z0 drv_data 0", bus_b.drv_data, 0);
        step();
        bus_b.req = 1'b0;
        step();
        check("z0 release drv_en", bus_b.drv_en, 0);
        check("z0 release busy", bus_b.busy, 0);
        bus_b.req = 1'b1; bus_b.wdata = 1'b1;
        step();
        check("z0 regrant drv_en", bus_b.drv_en, 1);
        bus_b.req = 1'b0;
        step();
        check("z0 final drv_en", bus_b.drv_en, 0);

        // Long hold on DUT a
        hi_cnt = 0; to_cnt = 0;
        bus_a.req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_a.drv_en) hi_cnt++;
            if (bus_a.timeout) to_cnt++;
        end
`ifdef TRI_TIMEOUT_EN
        check("long drive cycles", hi_cnt, 8);
        check("long timeout pulses", to_cnt, 1);
        check("lockout drv_en", bus_a.drv_en, 0);
        check("lockout busy", bus_a.busy, 0);
        bus_a.req = 1'b0;
        step();
        bus_a.req = 1'b1;
        step(); step();
        check("relock TURN_ON drv_en", bus_a.drv_en, 0);
        step();
        check("relock drive", bus_a.drv_en, 1);
`else
        check("long drive cycles", hi_cnt, 18);
        check("long timeout pulses", to_cnt, 0);
        check("long still driving", bus_a.drv_en, 1);
`endif

        // Async reset mid-drive
        #3;
        rst_n = 1'b0;
        #1;
        check("async drv_en", bus_a.drv_en, 0);
        check("async grant", bus_a.grant, 0);
        check("async busy", bus_a.busy, 0);
        bus_a.req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post rst busy", bus_a.busy, 0);
        check("post rst drv_data", bus_a.drv_data, 0);
        check("post rst drv_en", bus_a.drv_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
